// File: rtl/npc_bpred.sv
// Fetch PC register with a direct-mapped BTB and 2-bit direction counters.
// Predicts the next PC in fetch; repairs and trains from EX resolution.
module npc_bpred #(
  parameter int                ADDR_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [1:0]        res_kind,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] FOUR     = {{(ADDR_W-3){1'b0}}, 3'd4};
  localparam logic [1:0]        KIND_BR  = 2'b01;
  localparam logic [1:0]        KIND_J   = 2'b10;
  localparam logic [1:0]        KIND_JR  = 2'b11;

  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [BTB_DEPTH-1:0] uncond_q, uncond_d;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_d [BTB_DEPTH];
  logic [1:0]           ctr_q [BTB_DEPTH];
  logic [1:0]           ctr_d [BTB_DEPTH];

  logic [IDX_W-1:0]  lk_idx, rs_idx;
  logic [TAG_W-1:0]  lk_tag, rs_tag;
  logic              lk_hit, rs_hit;
  logic              res_active, act_taken, mispred;
  logic [ADDR_W-1:0] res_pc4;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign rs_idx = res_pc[IDX_W+1:2];
  assign rs_tag = res_pc[ADDR_W-1:IDX_W+2];
  assign rs_hit = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);

  assign pc          = pc_q;
  assign pc4         = pc_q + FOUR;
  assign pred_taken  = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
  assign pred_target = pred_taken ? tgt_q[lk_idx] : {ADDR_W{1'b0}};

  // Jumps are always taken; a taken branch must also match the travelled target.
  assign res_active  = res_valid && (res_kind != 2'b00);
  assign act_taken   = res_taken || (res_kind != KIND_BR);
  assign mispred     = res_active &&
                       ((act_taken != res_pred_taken) ||
                        (act_taken && (res_target != res_pred_target)));
  assign res_pc4     = res_pc + FOUR;
  assign flush       = mispred;
  assign redirect_pc = mispred ? (act_taken ? res_target : res_pc4) : {ADDR_W{1'b0}};

  // Next fetch PC: repair beats stall, stall beats prediction.
  always_comb begin
    pc_d = pc4;
    if (mispred) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end else begin
      pc_d = pc4;
    end
  end

  // BTB training from the resolved instruction, written at the same edge.
  always_comb begin
    valid_d  = valid_q;
    uncond_d = uncond_q;
    tag_d    = tag_q;
    tgt_d    = tgt_q;
    ctr_d    = ctr_q;
    case (res_active ? res_kind : 2'b00)
      KIND_BR: begin
        if (res_taken && rs_hit) begin
          tgt_d[rs_idx] = res_target;
          ctr_d[rs_idx] = (ctr_q[rs_idx] == 2'b11) ? 2'b11 : ctr_q[rs_idx] + 2'b01;
        end else if (res_taken) begin
          valid_d[rs_idx]  = 1'b1;
          uncond_d[rs_idx] = 1'b0;
          tag_d[rs_idx]    = rs_tag;
          tgt_d[rs_idx]    = res_target;
          ctr_d[rs_idx]    = 2'b10;
        end else begin
          ctr_d[rs_idx] = (rs_hit && (ctr_q[rs_idx] != 2'b00)) ?
                          ctr_q[rs_idx] - 2'b01 : ctr_q[rs_idx];
        end
      end
      KIND_J: begin
        valid_d[rs_idx]  = 1'b1;
        uncond_d[rs_idx] = 1'b1;
        tag_d[rs_idx]    = rs_tag;
        tgt_d[rs_idx]    = res_target;
        ctr_d[rs_idx]    = 2'b11;
      end
      KIND_JR: begin
        valid_d[rs_idx] = valid_q[rs_idx] && !rs_hit;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // State registers; reset also drops any in-flight training.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      valid_q  <= {BTB_DEPTH{1'b0}};
      uncond_q <= {BTB_DEPTH{1'b0}};
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i] <= {TAG_W{1'b0}};
        tgt_q[i] <= {ADDR_W{1'b0}};
        ctr_q[i] <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      uncond_q <= uncond_d;
      tag_q    <= tag_d;
      tgt_q    <= tgt_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Randomised and directed bench for npc_bpred against an address-level
// model of the BTB kept as per-slot records with integer counters.
module tb_npc_bpred;
  localparam int          D      = 16;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, pred_taken, flush;
  logic        res_valid, res_taken, res_pred_taken;
  logic [1:0]  res_kind;
  logic [31:0] pc, pc4, pred_target, redirect_pc;
  logic [31:0] res_pc, res_target, res_pred_target;

  int n_chk = 0;
  int n_pass = 0;

  // Model: each slot remembers the full PC that owns it.
  bit          m_v   [D];
  logic [31:0] m_epc [D];
  logic [31:0] m_tgt [D];
  bit          m_unc [D];
  int          m_ctr [D];
  logic [31:0] m_pc;

  logic        obs_pt, obs_flush;
  logic [31:0] obs_ptgt, obs_redir, obs_pc4, held;

  npc_bpred #(.ADDR_W(32), .BTB_DEPTH(D), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .pc4(pc4),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_kind(res_kind), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    else n_pass++;
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(D));
  endfunction

  function automatic bit hit_of(input logic [31:0] a);
    int i = idx_of(a);
    return m_v[i] && ((m_epc[i] / 32'(4 * D)) == (a / 32'(4 * D)));
  endfunction

  task automatic m_reset();
    m_pc = RST_PC;
    for (int k = 0; k < D; k++) begin
      m_v[k] = 1'b0; m_epc[k] = 32'h0; m_tgt[k] = 32'h0; m_unc[k] = 1'b0; m_ctr[k] = 1;
    end
  endtask

  task automatic alloc(input int r, input bit u, input int c);
    m_v[r] = 1'b1; m_epc[r] = res_pc; m_tgt[r] = res_target; m_unc[r] = u; m_ctr[r] = c;
  endtask

  task automatic idle();
    stall = 1'b0; res_valid = 1'b0; res_kind = 2'd0; res_pc = 32'h0; res_taken = 1'b0;
    res_target = 32'h0; res_pred_taken = 1'b0; res_pred_target = 32'h0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance both.
  task automatic cycle();
    int i, r;
    bit pt, act, mis, h;
    logic [31:0] ptgt, redir, nxt;
    @(negedge clk);
    i    = idx_of(m_pc);
    pt   = hit_of(m_pc) && (m_unc[i] || m_ctr[i] >= 2);
    ptgt = pt ? m_tgt[i] : 32'h0;
    act  = res_taken || (res_kind != 2'd1);
    mis  = res_valid && (res_kind != 2'd0) &&
           ((act != res_pred_taken) || (act && res_target != res_pred_target));
    redir = mis ? (act ? res_target : res_pc + 32'd4) : 32'h0;
    obs_pt = pred_taken; obs_ptgt = pred_target; obs_flush = flush;
    obs_redir = redirect_pc; obs_pc4 = pc4;
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
    chk("pred_target", pred_target, ptgt);
    chk("flush", {31'b0, flush}, {31'b0, mis});
    chk("redirect_pc", redirect_pc, redir);
    if (mis) nxt = redir;
    else if (stall) nxt = m_pc;
    else if (pt) nxt = ptgt;
    else nxt = m_pc + 32'd4;
    if (res_valid && res_kind != 2'd0) begin
      r = idx_of(res_pc);
      h = hit_of(res_pc);
      case (res_kind)
        2'd1: begin
          if (res_taken && h) begin
            m_tgt[r] = res_target;
            m_ctr[r] = (m_ctr[r] < 3) ? m_ctr[r] + 1 : 3;
          end else if (res_taken) alloc(r, 1'b0, 2);
          else if (h) m_ctr[r] = (m_ctr[r] > 0) ? m_ctr[r] - 1 : 0;
        end
        2'd2: alloc(r, 1'b1, 3);
        2'd3: if (h) m_v[r] = 1'b0;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_pc = nxt;
  endtask

  task automatic resolve(input logic [1:0] k, input logic [31:0] rpc, input logic tk,
                         input logic [31:0] tg, input logic ppt, input logic [31:0] ppg);
    res_valid = 1'b1; res_kind = k; res_pc = rpc; res_taken = tk;
    res_target = tg; res_pred_taken = ppt; res_pred_target = ppg;
    cycle();
    idle();
  endtask

  task automatic redirect_to(input logic [31:0] a);
    resolve(2'd3, 32'hF000_0000, 1'b1, a, 1'b0, 32'h0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset mid-cycle while a jump is being resolved.
    res_valid = 1'b1; res_kind = 2'd2; res_pc = RST_PC + 32'd16; res_taken = 1'b1;
    res_target = 32'h700; res_pred_taken = 1'b1; res_pred_target = 32'h700;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc4", pc4, 32'h0040_0004);
    chk("rst_pred", {31'b0, pred_taken}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    m_reset();
    repeat (3) cycle();
    chk("rst_3edges", pc, 32'h0040_000C);
    cycle();

    // Cold taken branch allocates at ctr=10.
    resolve(2'd1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("cold_flush", {31'b0, obs_flush}, 32'h1);
    chk("cold_redir", obs_redir, 32'h200);
    chk("cold_pc", pc, 32'h200);
    redirect_to(32'h100);
    cycle();
    chk("cold_pt", {31'b0, obs_pt}, 32'h1);
    chk("cold_ptgt", obs_ptgt, 32'h200);

    // Counter hysteresis and saturation.
    resolve(2'd1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    chk("hys_flush", {31'b0, obs_flush}, 32'h1);
    chk("hys_redir", obs_redir, 32'h104);
    redirect_to(32'h100);
    cycle();
    chk("hys_weak_nt", {31'b0, obs_pt}, 32'h0);
    repeat (2) resolve(2'd1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    redirect_to(32'h100);
    cycle();
    chk("hys_strong_t", {31'b0, obs_pt}, 32'h1);
    repeat (4) resolve(2'd1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h0);
    redirect_to(32'h100);
    cycle();
    chk("hys_sat_low", {31'b0, obs_pt}, 32'h0);

    // Stall holds the PC; a mispredict overrides it.
    stall = 1'b1;
    held = pc;
    repeat (3) cycle();
    chk("stall_hold", pc, held);
    resolve(2'd2, 32'h308, 1'b1, 32'h480, 1'b0, 32'h0);
    chk("stall_flush", pc, 32'h480);

    // Aliasing jumps, then register-jump invalidation.
    resolve(2'd2, 32'h100, 1'b1, 32'h600, 1'b0, 32'h0);
    resolve(2'd2, 32'h140, 1'b1, 32'h700, 1'b0, 32'h0);
    redirect_to(32'h100);
    cycle();
    chk("alias_miss", {31'b0, obs_pt}, 32'h0);
    redirect_to(32'h140);
    cycle();
    chk("alias_hit", {31'b0, obs_pt}, 32'h1);
    chk("alias_tgt", obs_ptgt, 32'h700);
    resolve(2'd3, 32'h140, 1'b1, 32'h700, 1'b1, 32'h700);
    redirect_to(32'h140);
    cycle();
    chk("jr_inval", {31'b0, obs_pt}, 32'h0);

    // Top-of-address-space wrap.
    redirect_to(32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc4", obs_pc4, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stall     = ($urandom_range(0, 3) == 0);
      res_valid = 1'($urandom_range(0, 1));
      res_kind  = 2'($urandom_range(0, 3));
      res_taken = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: res_pc = m_pc;
        1: res_pc = 32'h100 + 32'($urandom_range(0, 7)) * 32'h40;
        2: res_pc = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
        default: res_pc = $urandom;
      endcase
      res_target      = ($urandom_range(0, 1) == 1) ? 32'h100 + 32'($urandom_range(0, 31)) * 32'd4
                                                    : $urandom;
      res_pred_taken  = 1'($urandom_range(0, 1));
      res_pred_target = ($urandom_range(0, 1) == 1) ? res_target : $urandom;
      cycle();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
